lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store control stage directly upstream of the data memory.
- Accepts one load or store request at a time from the execute stage over a valid/ready handshake.
- Checks alignment and op legality, then drives the data-memory port (addr, read/write strobes, MemOp, write data) for a configurable access latency.
- Captures the already-extended load data and returns a response over a second valid/ready handshake.

Parameters:
- MEM_LAT, 1, cycles the memory strobe is held per access; legal range 1..15.
- CNT_W, 4, width of the latency counter; must satisfy MEM_LAT <= 2^CNT_W - 1.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  stage can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low bytes used for sub-word ops
- req_memop  in  3  000 sb/lb, 001 sh/lh, 010 sw/lw, 100 lbu, 101 lhu
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  load result, already extended by memory; 0 for stores and errors
- resp_err  out  1  misaligned or illegal access; no memory side effect
- mem_addr  out  32  to memory addr
- mem_rd  out  1  to memory MemRd
- mem_wr  out  1  to memory MemWr
- mem_op  out  3  to memory MemOp
- mem_wdata  out  32  to memory in
- mem_rdata  in  32  from memory out

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (async, immediate): state IDLE; resp_valid=0, resp_err=0, resp_rdata=0; mem_rd=0, mem_wr=0; mem_addr, mem_op, mem_wdata=0; req_ready=1 once released. Reset in ACCESS aborts the access and drops the strobes in the same instant; no write is issued afterwards.
- req_ready = (state==IDLE). A request fires when req_valid && req_ready. On fire, latch addr, wdata, memop and wen.
- Error check at fire (combinational on the request inputs):
  - memop in {011, 110, 111} -> error.
  - Store with memop 100 or 101 -> error.
  - Halfword ops (001, 101) with addr[0]=1 -> error.
  - Word op (010) with addr[1:0]!=00 -> error.
- Error path: IDLE -> RESP directly; resp_err=1, resp_rdata=0. Memory strobes are never asserted.
- Normal path: IDLE -> ACCESS. Counter loads MEM_LAT-1.
- mem_addr, mem_op and mem_wdata present the latched values throughout ACCESS and are 0 in other states.
- Load in ACCESS: mem_rd=1 for all MEM_LAT cycles. mem_rdata is sampled at the clock edge ending the cycle with counter==0, into resp_rdata.
- Store in ACCESS: mem_wr=1 only in the cycle with counter==0, so exactly one write per store. resp_rdata=0.
- Counter decrements each ACCESS cycle. At counter==0 the next state is RESP with resp_err=0.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_valid && resp_ready, then next state is IDLE.
- No bypass from RESP to a new request: a new request cannot be accepted in the same cycle a response is taken. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Latency from request fire to resp_valid: MEM_LAT+1 cycles on the normal path, 1 cycle on the error path.
- resp_ready held low stalls indefinitely in RESP; no new memory activity occurs while stalled.
- req_* inputs are ignored outside IDLE.

Test Plan:
- MEM_LAT=1, memory preloaded word 0x80000004=0x8899AABB; lb addr 0x80000005 -> mem_rd high 1 cycle, mem_addr=0x80000005, mem_op=000; resp_valid 2 cycles after fire with resp_rdata=0xFFFFFFAA, resp_err=0.
- MEM_LAT=3, sh addr 0x80000002 wdata 0x1234 -> mem_wr high exactly 1 cycle (third ACCESS cycle), mem_op=001; subsequent lw 0x80000000 returns 0x1234xxxx with the low half unchanged.
- lw addr 0x80000002 -> resp_err=1, resp_rdata=0 one cycle after fire; mem_rd and mem_wr never asserted. Repeat with sw memop 101 and memop 111 -> same result.
- resp_ready held 0 for 5 cycles after a load -> resp_valid stays 1 with rdata stable, req_ready=0, mem strobes 0; on resp_ready=1 the handshake completes and req_ready=1 the next cycle.
- MEM_LAT=3, rst asserted in the second ACCESS cycle of a store -> mem_wr never pulses and the target word is unchanged; after release req_ready=1 and resp_valid=0.
- Back-to-back lbu addr 0x80000007 then lhu addr 0x80000006 with req_valid held high -> second fire occurs only after the first response handshake; results are zero-extended (e.g. 0x00000088 and 0x00008899 for the preload above).

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store control stage in front of the data memory.
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake from execute (req_wen, req_addr, req_wdata, req_memop)
//   resp_valid/resp_ready response handshake (resp_rdata, resp_err)
//   mem_addr, mem_rd, mem_wr, mem_op, mem_wdata, mem_rdata  data-memory port
module lsu_mem_ctrl #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_memop,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [2:0]  mem_op,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [31:0] addr_q, wdata_q;
    logic [2:0] op_q;
    logic wen_q, fire, req_err, last;
    // illegal encodings, sub-word-unsigned stores, and misaligned half/word accesses
    assign req_err = (req_memop == 3'b011) || (req_memop[2:1] == 2'b11)
                   || (req_wen && req_memop[2])
                   || ((req_memop[1:0] == 2'b01) && req_addr[0])
                   || ((req_memop == 3'b010) && (req_addr[1:0] != 2'b00));
    assign req_ready  = (state == IDLE);
    assign fire       = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign last       = (state == ACCESS) && (cnt == '0);
    // strobes derive from state so an async reset drops them at once
    assign mem_addr  = (state == ACCESS) ? addr_q : 32'd0;
    assign mem_op    = (state == ACCESS) ? op_q : 3'd0;
    assign mem_wdata = (state == ACCESS) ? wdata_q : 32'd0;
    assign mem_rd    = (state == ACCESS) && !wen_q;
    assign mem_wr    = last && wen_q;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = fire ? (req_err ? RESP : ACCESS) : IDLE;
            ACCESS:  state_nx = last ? RESP : ACCESS;
            RESP:    state_nx = resp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= '0;
            wen_q      <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (fire) begin
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                op_q       <= req_memop;
                wen_q      <= req_wen;
                cnt        <= CNT_W'(MEM_LAT - 1);
                resp_err   <= req_err;
                resp_rdata <= '0;
            end
            if (state == ACCESS && !last)
                cnt <= cnt - 1'b1;
            if (last && !wen_q)
                resp_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed table-driven bench for lsu_mem_ctrl with a word-array memory model.
module tb_lsu_mem_ctrl;
    localparam int LAT = 3;
    logic clk = 0, rst = 1;
    logic req_valid = 0, req_wen = 0, resp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [2:0] req_memop = 0;
    logic req_ready, resp_valid, resp_err, mem_rd, mem_wr;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0] mem_op;
    logic [31:0] mem [4];
    int tests = 0, fails = 0, wr_total = 0;

    lsu_mem_ctrl #(.MEM_LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_memop(req_memop),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_op(mem_op),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [31:0] w;
        logic [7:0] b;
        logic [15:0] h;
        w = mem[mem_addr[3:2]];
        b = 8'(w >> {mem_addr[1:0], 3'b000});
        h = 16'(w >> {mem_addr[1], 4'b0000});
        mem_rdata = w;
        case (mem_op)
            3'b000: mem_rdata = {{24{b[7]}}, b};
            3'b100: mem_rdata = {24'd0, b};
            3'b001: mem_rdata = {{16{h[15]}}, h};
            3'b101: mem_rdata = {16'd0, h};
            default: mem_rdata = w;
        endcase
    end

    always @(posedge clk)
        if (mem_wr)
            case (mem_op[1:0])
                2'b00: mem[mem_addr[3:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
                2'b01: mem[mem_addr[3:2]][16*mem_addr[1] +: 16] <= mem_wdata[15:0];
                default: mem[mem_addr[3:2]] <= mem_wdata;
            endcase

    always @(negedge clk) if (mem_wr) wr_total++;

    typedef struct {
        logic wen; logic [2:0] op; logic [31:0] addr; logic [31:0] wdata;
        logic err; logic [31:0] rdata;
    } vec_t;
    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_req(input vec_t v, input int idx);
        int n, rd, wr, wr_n, bad;
        @(negedge clk);
        chk($sformatf("v%0d ready", idx), 32'(req_ready), 1);
        req_valid = 1; req_wen = v.wen; req_memop = v.op; req_addr = v.addr; req_wdata = v.wdata;
        n = 0; rd = 0; wr = 0; wr_n = -1; bad = 0;
        do begin
            @(negedge clk);
            n++;
            req_valid = 0;
            if (mem_rd) rd++;
            if (mem_wr) begin wr++; wr_n = n; end
            if ((mem_rd || mem_wr) && (mem_addr !== v.addr || mem_op !== v.op || (v.wen && mem_wdata !== v.wdata)))
                bad++;
        end while (!resp_valid && n < 40);
        chk($sformatf("v%0d latency", idx), 32'(n), v.err ? 1 : LAT + 1);
        chk($sformatf("v%0d err", idx), 32'(resp_err), 32'(v.err));
        chk($sformatf("v%0d rdata", idx), resp_rdata, v.rdata);
        chk($sformatf("v%0d rd_cycles", idx), 32'(rd), (!v.wen && !v.err) ? LAT : 0);
        chk($sformatf("v%0d wr_cycles", idx), 32'(wr), (v.wen && !v.err) ? 1 : 0);
        if (v.wen && !v.err) chk($sformatf("v%0d wr_cycle_pos", idx), 32'(wr_n), LAT);
        chk($sformatf("v%0d port_fields", idx), 32'(bad), 0);
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        chk($sformatf("v%0d resp_done", idx), 32'(resp_valid), 0);
        chk($sformatf("v%0d ready_after", idx), 32'(req_ready), 1);
    endtask

    initial begin
        int n, wr0;
        logic [31:0] held;
        mem[0] = 32'h11223344; mem[1] = 32'h8899AABB; mem[2] = 32'h55667788; mem[3] = 32'h0;
        vecs[0]  = '{0, 3'b000, 32'h80000005, 0, 0, 32'hFFFFFFAA};
        vecs[1]  = '{0, 3'b100, 32'h80000007, 0, 0, 32'h00000088};
        vecs[2]  = '{0, 3'b101, 32'h80000006, 0, 0, 32'h00008899};
        vecs[3]  = '{0, 3'b001, 32'h80000006, 0, 0, 32'hFFFF8899};
        vecs[4]  = '{0, 3'b010, 32'h80000004, 0, 0, 32'h8899AABB};
        vecs[5]  = '{1, 3'b001, 32'h80000002, 32'hDEAD1234, 0, 0};
        vecs[6]  = '{0, 3'b010, 32'h80000000, 0, 0, 32'h12343344};
        vecs[7]  = '{1, 3'b000, 32'h80000009, 32'hFFFFFF5A, 0, 0};
        vecs[8]  = '{0, 3'b010, 32'h80000008, 0, 0, 32'h55665A88};
        vecs[9]  = '{1, 3'b010, 32'h8000000C, 32'hCAFEF00D, 0, 0};
        vecs[10] = '{0, 3'b010, 32'h8000000C, 0, 0, 32'hCAFEF00D};
        vecs[11] = '{0, 3'b000, 32'h80000008, 0, 0, 32'hFFFFFF88};
        vecs[12] = '{0, 3'b010, 32'h80000002, 0, 1, 0};
        vecs[13] = '{1, 3'b101, 32'h80000004, 32'h1, 1, 0};
        vecs[14] = '{0, 3'b111, 32'h80000004, 0, 1, 0};
        vecs[15] = '{0, 3'b011, 32'h80000004, 0, 1, 0};
        vecs[16] = '{0, 3'b001, 32'h80000001, 0, 1, 0};
        vecs[17] = '{1, 3'b010, 32'h8000000E, 32'hFFFFFFFF, 1, 0};
        vecs[18] = '{1, 3'b100, 32'h80000004, 32'hFF, 1, 0};
        vecs[19] = '{0, 3'b110, 32'h80000000, 0, 1, 0};

        #12;
        chk("rst resp_valid", 32'(resp_valid), 0);
        chk("rst resp_err", 32'(resp_err), 0);
        chk("rst resp_rdata", resp_rdata, 0);
        chk("rst strobes", {30'd0, mem_rd, mem_wr}, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_op_wdata", {mem_op, mem_wdata[28:0]}, 0);
        @(negedge clk); rst = 0;
        @(negedge clk);
        chk("rst req_ready", 32'(req_ready), 1);

        for (int i = 0; i < 20; i++) run_req(vecs[i], i);
        chk("mem after stores w0", mem[0], 32'h12343344);
        chk("mem after stores w1", mem[1], 32'h8899AABB);

        // response stall with resp_ready low for five cycles
        @(negedge clk);
        req_valid = 1; req_wen = 0; req_memop = 3'b010; req_addr = 32'h80000004;
        @(negedge clk); req_valid = 0;
        n = 0;
        while (!resp_valid && n < 40) begin @(negedge clk); n++; end
        chk("stall reached resp", 32'(resp_valid), 1);
        held = resp_rdata;
        chk("stall rdata", held, 32'h8899AABB);
        req_valid = 1; req_wen = 1; req_memop = 3'b010; req_addr = 32'h80000004; req_wdata = 0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_rdata !== held || req_ready || mem_rd || mem_wr) n++;
        end
        chk("stall hold violations", 32'(n), 0);
        req_valid = 0;
        resp_ready = 1;
        @(negedge clk); resp_ready = 0;
        chk("stall handshake done", 32'(resp_valid), 0);
        chk("stall ready after", 32'(req_ready), 1);
        chk("stall store ignored", mem[1], 32'h8899AABB);

        // back-to-back with req_valid held high
        @(negedge clk);
        req_valid = 1; req_wen = 0; req_memop = 3'b100; req_addr = 32'h80000007;
        @(negedge clk);
        req_memop = 3'b101; req_addr = 32'h80000006;
        n = 1;
        while (!resp_valid && n < 40) begin @(negedge clk); n++; end
        chk("b2b first latency", 32'(n), LAT + 1);
        chk("b2b first rdata", resp_rdata, 32'h00000088);
        chk("b2b no fire in resp", 32'(req_ready), 0);
        resp_ready = 1;
        @(negedge clk); resp_ready = 0;
        chk("b2b ready for second", 32'(req_ready), 1);
        @(negedge clk); req_valid = 0;
        n = 1;
        while (!resp_valid && n < 40) begin @(negedge clk); n++; end
        chk("b2b second latency", 32'(n), LAT + 1);
        chk("b2b second rdata", resp_rdata, 32'h00008899);
        resp_ready = 1;
        @(negedge clk); resp_ready = 0;

        // async reset in the second ACCESS cycle of a store
        @(negedge clk);
        wr0 = wr_total;
        req_valid = 1; req_wen = 1; req_memop = 3'b010; req_addr = 32'h80000008; req_wdata = 32'hFFFFFFFF;
        @(negedge clk); req_valid = 0;
        @(negedge clk);
        rst = 1;
        #1;
        chk("arst mem_wr", 32'(mem_wr), 0);
        chk("arst mem_addr", mem_addr, 0);
        @(negedge clk); rst = 0;
        repeat (LAT + 2) @(negedge clk);
        chk("arst no write", 32'(wr_total - wr0), 0);
        chk("arst mem unchanged", mem[2], 32'h55665A88);
        chk("arst req_ready", 32'(req_ready), 1);
        chk("arst resp_valid", 32'(resp_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
